// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Stall/flush control for the 5-stage MIPS pipeline. It detects load-use and
// branch-operand hazards against the Execute and Memory stages, and holds
// HI/LO readers and new multiply/divide ops in Decode while the multi-cycle
// multiply/divide unit is still busy.

module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic        useRtD,
    input  logic        branchD,
    input  logic        branchTakenD,
    input  logic        hiloReadD,
    input  logic        mdOpD,
    input  logic        memReadE,
    input  logic        regWriteE,
    input  logic [4:0]  writeRegE,
    input  logic        memReadM,
    input  logic [4:0]  writeRegM,
    input  logic        mdStartE,
    input  logic        mdIsDivE,
    output logic        stallF,
    output logic        stallD,
    output logic        flushD,
    output logic        flushE,
    output logic        mdBusy,
    output logic        mdDone,
    output logic [15:0] stallCycles
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES);
    localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES);

    logic [0:0] state;
    logic [5:0] cnt;

    logic matchE;
    logic matchM;
    logic lwStall;
    logic brStall;
    logic mdStall;
    logic stall;

    // Hazard detection: compare Decode source registers against the
    // destinations still in flight; register 0 never creates a dependency.
    always_comb begin
        matchE  = regWriteE && (writeRegE != 5'd0) &&
                  ((writeRegE == rsD) || (useRtD && (writeRegE == rtD)));
        matchM  = memReadM && (writeRegM != 5'd0) &&
                  ((writeRegM == rsD) || (useRtD && (writeRegM == rtD)));
        lwStall = memReadE && matchE;
        brStall = branchD && (matchE || matchM);
        mdStall = mdBusy && (hiloReadD || mdOpD);
        stall   = lwStall || brStall || mdStall;
    end

    // A stalled taken branch must not redirect fetch until the stall clears,
    // otherwise the branch would be squashed-and-retaken twice.
    assign stallF = stall;
    assign stallD = stall;
    assign flushE = stall;
    assign flushD = branchTakenD && !stall;
    assign mdBusy = (state == BUSY);

    // Multiply/divide occupancy tracker: load the op latency on start, count
    // down while busy and pulse mdDone in the first idle cycle afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 6'd0;
            mdDone <= 1'b0;
        end else begin
            mdDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (mdStartE) begin
                        cnt   <= mdIsDivE ? DIV_LOAD : MULT_LOAD;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1) begin
                        state  <= IDLE;
                        mdDone <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 6'd0;
                end
            endcase
        end
    end

    // Performance counter of stalled Decode cycles, pinned at its maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCycles <= 16'd0;
        end else if (stallD && (stallCycles != 16'hFFFF)) begin
            stallCycles <= stallCycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl
// Cycle-level bench: each cycle's stimulus pushes the expected control vector
// and stall count into a queue; the sample half-way through the cycle pops
// and compares it.

module tb_hazard_stall_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  rsD;
    logic [4:0]  rtD;
    logic        useRtD;
    logic        branchD;
    logic        branchTakenD;
    logic        hiloReadD;
    logic        mdOpD;
    logic        memReadE;
    logic        regWriteE;
    logic [4:0]  writeRegE;
    logic        memReadM;
    logic [4:0]  writeRegM;
    logic        mdStartE;
    logic        mdIsDivE;
    logic        stallF;
    logic        stallD;
    logic        flushD;
    logic        flushE;
    logic        mdBusy;
    logic        mdDone;
    logic [15:0] stallCycles;

    typedef struct {
        logic [5:0]  ctl;
        logic [15:0] sc;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [15:0] scCount;
    int          checks;
    int          errors;

    hazard_stall_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .useRtD(useRtD),
        .branchD(branchD), .branchTakenD(branchTakenD), .hiloReadD(hiloReadD),
        .mdOpD(mdOpD), .memReadE(memReadE), .regWriteE(regWriteE),
        .writeRegE(writeRegE), .memReadM(memReadM), .writeRegM(writeRegM),
        .mdStartE(mdStartE), .mdIsDivE(mdIsDivE), .stallF(stallF),
        .stallD(stallD), .flushD(flushD), .flushE(flushE), .mdBusy(mdBusy),
        .mdDone(mdDone), .stallCycles(stallCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control vector layout: {stallF, stallD, flushE, flushD, mdBusy, mdDone}
    function automatic logic [5:0] mk(input logic s, input logic f, input logic b, input logic d);
        return {s, s, s, f, b, d};
    endfunction

    function automatic logic [5:0] obs();
        return {stallF, stallD, flushE, flushD, mdBusy, mdDone};
    endfunction

    // Push this cycle's expectation and advance the stall-count model.
    function automatic void expect_cycle(input logic s, input logic f, input logic b,
                                         input logic d, input logic r);
        q.push_back('{mk(s, f, b, d), scCount});
        if (r) scCount = 16'd0;
        else if (s && scCount != 16'hFFFF) scCount = scCount + 16'd1;
    endfunction

    task automatic idle_inputs();
        rsD = 5'd0; rtD = 5'd0; useRtD = 1'b0; branchD = 1'b0; branchTakenD = 1'b0;
        hiloReadD = 1'b0; mdOpD = 1'b0; memReadE = 1'b0; regWriteE = 1'b0;
        writeRegE = 5'd0; memReadM = 1'b0; writeRegM = 5'd0; mdStartE = 1'b0;
        mdIsDivE = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            idle_inputs();
            rst = (i < 2);
            if (i == 1) begin
                memReadE = 1'b1; regWriteE = 1'b1; writeRegE = 5'd8; rsD = 5'd8;
                expect_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            end else begin
                expect_cycle(1'b0, 1'b0, 1'b0, 1'b0, rst);
            end
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e.ctl) begin errors++; $display("[TB] FAIL reset cyc%0d ctl got %b want %b", i, obs(), e.ctl); end
            checks++;
            if (stallCycles !== e.sc) begin errors++; $display("[TB] FAIL reset cyc%0d stallCycles got %0d want %0d", i, stallCycles, e.sc); end
            checks++;
            if (dut.cnt !== 6'd0) begin errors++; $display("[TB] FAIL reset cyc%0d cnt got %0d want 0", i, dut.cnt); end
        end
    endtask

    task automatic test_load_use();
        logic s;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            idle_inputs();
            s = 1'b0;
            case (i)
                0: begin memReadE = 1; regWriteE = 1; writeRegE = 5'd8; rsD = 5'd8; s = 1; end
                1: begin memReadM = 1; writeRegM = 5'd8; rsD = 5'd8; end
                2: begin memReadE = 1; regWriteE = 1; writeRegE = 5'd0; rsD = 5'd0; rtD = 5'd0; useRtD = 1; end
                3: begin memReadE = 1; regWriteE = 1; writeRegE = 5'd12; rsD = 5'd3; rtD = 5'd12; end
                4: begin memReadE = 1; regWriteE = 1; writeRegE = 5'd12; rsD = 5'd3; rtD = 5'd12; useRtD = 1; s = 1; end
                5: begin memReadE = 1; writeRegE = 5'd12; rsD = 5'd12; end
                default: ;
            endcase
            expect_cycle(s, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e.ctl) begin errors++; $display("[TB] FAIL load_use cyc%0d ctl got %b want %b", i, obs(), e.ctl); end
            checks++;
            if (stallCycles !== e.sc) begin errors++; $display("[TB] FAIL load_use cyc%0d stallCycles got %0d want %0d", i, stallCycles, e.sc); end
        end
    endtask

    task automatic test_branch();
        logic s;
        logic f;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            idle_inputs();
            s = 1'b0; f = 1'b0;
            case (i)
                0: begin branchD = 1; branchTakenD = 1; rsD = 5'd9; memReadE = 1; regWriteE = 1; writeRegE = 5'd9; s = 1; end
                1: begin branchD = 1; branchTakenD = 1; rsD = 5'd9; memReadM = 1; writeRegM = 5'd9; s = 1; end
                2: begin branchD = 1; branchTakenD = 1; rsD = 5'd9; f = 1; end
                3: begin branchD = 1; rtD = 5'd10; useRtD = 1; regWriteE = 1; writeRegE = 5'd10; s = 1; end
                4: begin branchD = 1; rtD = 5'd10; useRtD = 1; writeRegM = 5'd10; end
                5: begin branchD = 1; branchTakenD = 1; memReadM = 1; writeRegM = 5'd0; memReadE = 1; regWriteE = 1; f = 1; end
                6: begin branchD = 1; branchTakenD = 1; rsD = 5'd5; regWriteE = 1; writeRegE = 5'd5; s = 1; end
                default: ;
            endcase
            expect_cycle(s, f, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e.ctl) begin errors++; $display("[TB] FAIL branch cyc%0d ctl got %b want %b", i, obs(), e.ctl); end
            checks++;
            if (stallCycles !== e.sc) begin errors++; $display("[TB] FAIL branch cyc%0d stallCycles got %0d want %0d", i, stallCycles, e.sc); end
        end
    endtask

    // One multiply or divide with a dependent instruction waiting in Decode;
    // a stray start in busy cycle 3 must be ignored.
    task automatic test_md_op(input int n, input logic isDiv, input logic useHilo);
        logic b;
        logic d;
        logic s;
        for (int i = 0; i <= n + 2; i++) begin
            @(posedge clk); #1;
            idle_inputs();
            b = (i >= 1 && i <= n);
            d = (i == n + 1);
            s = 1'b0;
            if (i == 0) begin
                mdStartE = 1'b1; mdIsDivE = isDiv;
            end else if (i <= n + 1) begin
                if (useHilo) hiloReadD = 1'b1;
                else mdOpD = 1'b1;
                s = b;
                if (i == 3) begin mdStartE = 1'b1; mdIsDivE = ~isDiv; end
            end
            expect_cycle(s, 1'b0, b, d, 1'b0);
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e.ctl) begin errors++; $display("[TB] FAIL md_op n=%0d cyc%0d ctl got %b want %b", n, i, obs(), e.ctl); end
            checks++;
            if (stallCycles !== e.sc) begin errors++; $display("[TB] FAIL md_op n=%0d cyc%0d stallCycles got %0d want %0d", n, i, stallCycles, e.sc); end
            if (i == 1) begin
                checks++;
                if (dut.cnt !== 6'(n)) begin errors++; $display("[TB] FAIL md_op load cnt got %0d want %0d", dut.cnt, n); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic b;
        logic d;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            idle_inputs();
            if (i == 0) begin mdStartE = 1'b1; mdIsDivE = 1'b0; end
            if (i == 5) begin mdStartE = 1'b1; mdIsDivE = 1'b1; end
            b = (i >= 1 && i <= 4) || (i >= 6 && i <= 37);
            d = (i == 5) || (i == 38);
            expect_cycle(1'b0, 1'b0, b, d, 1'b0);
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e.ctl) begin errors++; $display("[TB] FAIL back_to_back cyc%0d ctl got %b want %b", i, obs(), e.ctl); end
            if (i == 6) begin
                checks++;
                if (dut.cnt !== 6'd32) begin errors++; $display("[TB] FAIL back_to_back reload cnt got %0d want 32", dut.cnt); end
            end
        end
    endtask

    task automatic test_reset_mid_div();
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            idle_inputs();
            rst = (i == 10);
            if (i == 0) begin mdStartE = 1'b1; mdIsDivE = 1'b1; end
            expect_cycle(1'b0, 1'b0, (i >= 1 && i <= 10), 1'b0, rst);
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e.ctl) begin errors++; $display("[TB] FAIL reset_mid_div cyc%0d ctl got %b want %b", i, obs(), e.ctl); end
            checks++;
            if (stallCycles !== e.sc) begin errors++; $display("[TB] FAIL reset_mid_div cyc%0d stallCycles got %0d want %0d", i, stallCycles, e.sc); end
            if (i == 11) begin
                checks++;
                if (dut.cnt !== 6'd0) begin errors++; $display("[TB] FAIL reset_mid_div cnt got %0d want 0", dut.cnt); end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_saturate();
        logic s;
        for (int i = 0; i < 65542; i++) begin
            @(posedge clk); #1;
            idle_inputs();
            s = (i < 65540);
            if (s) begin memReadE = 1'b1; regWriteE = 1'b1; writeRegE = 5'd7; rsD = 5'd7; end
            expect_cycle(s, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            e = q.pop_front();
            if (i < 2 || i >= 65532) begin
                checks++;
                if (obs() !== e.ctl) begin errors++; $display("[TB] FAIL saturate cyc%0d ctl got %b want %b", i, obs(), e.ctl); end
                checks++;
                if (stallCycles !== e.sc) begin errors++; $display("[TB] FAIL saturate cyc%0d stallCycles got %0h want %0h", i, stallCycles, e.sc); end
            end
        end
    endtask

    // Hard time limit so the bench can never hang.
    initial begin
        #950000;
        $display("[TB] FAIL watchdog time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    // Run every scenario in sequence, then report.
    initial begin
        checks = 0;
        errors = 0;
        scCount = 16'd0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_branch();
        test_md_op(32, 1'b1, 1'b1);
        test_md_op(4, 1'b0, 1'b0);
        test_back_to_back();
        test_reset_mid_div();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and sequencing controller for the 5-stage MIPS datapath. It inspects the Decode, Execute and Memory stage fields and produces the stall and flush controls for the F/D and D/E pipeline registers, including the bubble-insertion flush into the D-to-E register. It also owns the multi-cycle multiply/divide busy tracker. Instructions reading HI/LO, or issuing another multiply/divide while the unit is busy, are held in Decode until the result is ready.

## Interface
- MULT_CYCLES, 4: Execute-unit occupancy of a mult/multu, in cycles (≥1).
- DIV_CYCLES, 32: Execute-unit occupancy of a div/divu, in cycles (≥1, ≤63).
- Reset is rst, synchronous, active-high; clock is clk.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rsD  in  5  Decode rs field
- rtD  in  5  Decode rt field
- useRtD  in  1  Decode instruction reads rt
- branchD  in  1  Decode holds a branch comparing rs/rt in Decode
- branchTakenD  in  1  branch in Decode resolves taken
- hiloReadD  in  1  Decode is mfhi/mflo
- mdOpD  in  1  Decode is mult/multu/div/divu
- memReadE  in  1  Execute is a load
- regWriteE  in  1  Execute writes the register file
- writeRegE  in  5  Execute destination register
- memReadM  in  1  Memory is a load
- writeRegM  in  5  Memory destination register
- mdStartE  in  1  mult/div enters Execute this cycle (already qualified by flushE)
- mdIsDivE  in  1  with mdStartE: 1 = divide, 0 = multiply
- stallF  out  1  hold PC
- stallD  out  1  hold F/D register
- flushD  out  1  clear F/D register (taken branch)
- flushE  out  1  drive D-to-E register rst (bubble)
- mdBusy  out  1  mult/div unit occupied
- mdDone  out  1  one-cycle pulse: HI/LO valid
- stallCycles  out  16  saturating count of stalled cycles

## Operation
- matchE = regWriteE & (writeRegE≠0) & (writeRegE==rsD | (useRtD & writeRegE==rtD)).
- matchM = memReadM & (writeRegM≠0) & (writeRegM==rsD | (useRtD & writeRegM==rtD)).
- lwStall = memReadE & matchE.
- brStall = branchD & (matchE | matchM).
- mdStall = mdBusy & (hiloReadD | mdOpD).
- stall = lwStall | brStall | mdStall. stallF = stallD = flushE = stall. These outputs are combinational from the inputs and the current state.
- flushD = branchTakenD & ~stall. A taken branch that is stalled does not redirect until its stall clears.
- FSM states:
  - IDLE: mdBusy=0. On mdStartE, load cnt = DIV_CYCLES if mdIsDivE, else MULT_CYCLES, and go to BUSY.
  - BUSY: mdBusy=1. Decrement cnt each cycle. When cnt==1, go to IDLE and register mdDone=1 for the next cycle.
  - mdStartE while BUSY is ignored; a hazard stall prevents it in legal code.
- mdDone is high for exactly one cycle, the first IDLE cycle after BUSY.
- An mdStartE in that same cycle is accepted normally (back-to-back).
- cnt is 6 bits wide.
- stallCycles increments on every cycle with stallD=1 and holds at 0xFFFF.

## Timing
- Reset values: state IDLE, cnt 0, mdBusy 0, mdDone 0, stallCycles 0.
- With rst=1 and state IDLE, stall/flush outputs follow their combinational equations.
- A reset in the middle of BUSY returns to IDLE on the next edge, with no mdDone pulse.
- Load-use: exactly one stall cycle. The load moves to M, lwStall drops, and forwarding covers the rest.
- Branch after ALU op: 1 stall cycle. Branch after load: 2 stall cycles (E, then M).
- mdStartE sampled at edge t: mdBusy is high for cycles t+1 … t+N, and mdDone is high in cycle t+N+1.
  - N = MULT_CYCLES or DIV_CYCLES.
- An mfhi in Decode during BUSY stalls through cycle t+N and proceeds in t+N+1.
- A register index of 0 never causes a stall.

## Test plan
- Reset: apply rst for 2 cycles -> mdBusy=0, mdDone=0, stallCycles=0, cnt=0.
- Load-use: lw writes $8 in E; Decode add reads rs=8 -> stallF=stallD=flushE=1 for 1 cycle; stallCycles=1. Repeat with writeRegE=0 -> no stall.
- Branch after load: beq with rs=9; load to $9 in E, then in M -> stall for 2 cycles. With branchTakenD=1, flushD=0 during both stall cycles and flushD=1 in the third cycle.
- Divide: mdStartE=1, mdIsDivE=1 -> mdBusy high for 32 cycles, then mdDone for 1 cycle. mfhi held in Decode stalls 32 cycles. Multiply gives 4 busy cycles.
- Back-to-back: a new mdStartE in the mdDone cycle -> BUSY is re-entered with no idle gap and cnt is reloaded.
- Reset mid-divide at busy cycle 10 -> IDLE next cycle, mdBusy=0, no mdDone. Also drive more than 65535 stall cycles -> stallCycles saturates at 0xFFFF.
